// File: rtl/rf_scoreboard_pkg.sv
// Shared types and helpers for the register-file scoreboard.
package rf_scoreboard_pkg;

  localparam int unsigned REG_IDX_W     = 5;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned INFLIGHT_W    = 6;

  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [INFLIGHT_W-1:0] inflight_t;

  // One saturating step of the total in-flight write count, clamped to [0, 2^W-1].
  function automatic inflight_t inflight_step(input inflight_t cur, input logic inc,
                                              input logic dec);
    inflight_t nxt;
    nxt = cur;
    if (inc && !dec && (cur != '1)) begin
      nxt = cur + inflight_t'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - inflight_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Issue (Dispatcher), writeback (Committer) and flush signals seen by the scoreboard.
interface rf_scoreboard_if;

  logic                          issue_valid;
  logic                          issue_ready;
  rf_scoreboard_pkg::reg_idx_t   issue_rs1;
  rf_scoreboard_pkg::reg_idx_t   issue_rs2;
  logic                          issue_rs1_used;
  logic                          issue_rs2_used;
  rf_scoreboard_pkg::reg_idx_t   issue_rd;
  logic                          issue_rd_we;
  logic                          wb_valid;
  rf_scoreboard_pkg::reg_idx_t   wb_rd;
  logic                          wb_we;
  logic                          flush;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_rd_we, wb_valid, wb_rd, wb_we, flush,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_rd_we, wb_valid, wb_rd, wb_we, flush,
    output issue_ready
  );

endinterface

// File: rtl/rf_scoreboard_sb_counter.sv
// Per-register pending-write counter: up/down with synchronous clear.
module rf_scoreboard_sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign full = (cnt_q == '1);

endmodule

// File: rtl/rf_scoreboard.sv
// Tracks in-flight register writes; stalls issue on RAW hazards and on counter saturation.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS     = NREGS_DEFAULT,
  parameter int unsigned CNT_W     = 2,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_scoreboard_if.slave       sb,
  output inflight_t            inflight_cnt,
  output logic [NREGS-1:0]     busy,
  output logic                 err_underflow
);

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            zero;
  logic [NREGS-1:0]            full;
  logic [NREGS-1:0]            inc;
  logic [NREGS-1:0]            dec;
  logic [NREGS-1:0]            eff_nz;
  logic [NREGS-1:0]            eff_full;

  logic      hazard;
  logic      issue_fire;
  logic      inc_any;
  logic      dec_any;
  logic      underflow_hit;
  inflight_t inflight_q, inflight_d;
  logic      err_q;

  // x0 is never tracked: it reads as an empty counter that cannot change.
  assign cnt[0]      = '0;
  assign zero[0]     = 1'b1;
  assign full[0]     = 1'b0;
  assign inc[0]      = 1'b0;
  assign dec[0]      = 1'b0;
  assign eff_nz[0]   = 1'b0;
  assign eff_full[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    assign inc[i] = issue_fire && sb.issue_rd_we && (sb.issue_rd == reg_idx_t'(i));
    assign dec[i] = sb.wb_valid && sb.wb_we && (sb.wb_rd == reg_idx_t'(i)) && !zero[i];

    // With bypass, a writeback retiring the last pending write releases the hazard now.
    if (WB_BYPASS) begin : g_byp
      assign eff_nz[i]   = !(zero[i] || (dec[i] && (cnt[i] == CNT_W'(1))));
      assign eff_full[i] = full[i] && !dec[i];
    end else begin : g_nobyp
      assign eff_nz[i]   = !zero[i];
      assign eff_full[i] = full[i];
    end

    rf_scoreboard_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[i]),
      .dec  (dec[i]),
      .clr  (sb.flush),
      .cnt  (cnt[i]),
      .zero (zero[i]),
      .full (full[i])
    );
  end

  assign hazard = (sb.issue_rs1_used && eff_nz[sb.issue_rs1])
               || (sb.issue_rs2_used && eff_nz[sb.issue_rs2])
               || (sb.issue_rd_we    && eff_full[sb.issue_rd]);

  assign sb.issue_ready = !rst && !sb.flush && !hazard;
  assign issue_fire     = sb.issue_valid && sb.issue_ready;

  assign inc_any = issue_fire && sb.issue_rd_we && (sb.issue_rd != '0);
  assign dec_any = |dec;

  // A writeback that lands together with a flush is discarded, including its error check.
  assign underflow_hit = sb.wb_valid && sb.wb_we && (sb.wb_rd != '0) && zero[sb.wb_rd]
                      && !sb.flush;

  always_comb begin
    inflight_d = inflight_step(inflight_q, inc_any, dec_any);
    if (sb.flush) begin
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (underflow_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign inflight_cnt  = inflight_q;
  assign busy          = ~zero;
  assign err_underflow = err_q;

endmodule
